// File: rtl/tcm_ctrl.sv
// Bus-side TCM controller in front of sim_ram: valid/ready commands in, one response per command out.
// Absorbs the 1-cycle RAM read latency and holds read data across response back-pressure.
module tcm_ctrl #(
    parameter int              DP        = 512,
    parameter int              DW        = 32,
    parameter int              MW        = 4,
    parameter int              AW        = 32,
    parameter int              RAW       = 9,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_read,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [DW-1:0]  cmd_wdata,
    input  logic [MW-1:0]  cmd_wmask,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_din,
    output logic           ram_we,
    output logic [MW-1:0]  ram_wem,
    input  logic [DW-1:0]  ram_dout
);

    logic           en_q, en_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           is_read_q, is_read_d;
    logic           err_q, err_d;
    logic           fresh_q, fresh_d;
    logic [DW-1:0]  hold_q, hold_d;

    logic           acc_s;
    logic           in_range_s;
    logic           unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^cmd_addr[1:0];

    // Command-side handshake, window decode and RAM drive
    always_comb begin
        in_range_s = (cmd_addr[AW-1:RAW+2] == BASE_ADDR[AW-1:RAW+2]);
        cmd_ready  = en_q & (~rsp_valid_q | rsp_ready);
        acc_s      = cmd_valid & cmd_ready;
        ram_addr   = {{(AW-RAW){1'b0}}, cmd_addr[RAW+1:2]};
        ram_din    = cmd_wdata;
        ram_wem    = cmd_wmask;
        ram_we     = acc_s & ~cmd_read & in_range_s;
    end

    // Next state of the single response stage
    always_comb begin
        en_d        = 1'b1;
        rsp_valid_d = rsp_valid_q;
        is_read_d   = is_read_q;
        err_d       = err_q;
        fresh_d     = fresh_q;
        hold_d      = hold_q;
        if (acc_s) begin
            rsp_valid_d = 1'b1;
            is_read_d   = cmd_read & in_range_s;
            err_d       = ~in_range_s;
            fresh_d     = 1'b1;
        end else if (rsp_valid_q & rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else if (rsp_valid_q & fresh_q) begin
            // Stalled: capture RAM data before its address register follows cmd_addr
            hold_d  = ram_dout;
            fresh_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            is_read_q   <= 1'b0;
            err_q       <= 1'b0;
            fresh_q     <= 1'b0;
            hold_q      <= {DW{1'b0}};
        end else begin
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            is_read_q   <= is_read_d;
            err_q       <= err_d;
            fresh_q     <= fresh_d;
            hold_q      <= hold_d;
        end
    end

    // Response outputs
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_err   = err_q;
        if (!is_read_q) begin
            rsp_rdata = {DW{1'b0}};
        end else if (fresh_q) begin
            rsp_rdata = ram_dout;
        end else begin
            rsp_rdata = hold_q;
        end
    end

endmodule

// File: doc/tcm_ctrl.md
Name: tcm_ctrl

Overview:
- Bus-side controller directly upstream of sim_ram, for both the ITCM and DTCM instances.
- Accepts valid/ready commands from the core's load/store or fetch unit. Translates each byte address to a word index and drives the RAM's din/addr/we/wem.
- Returns one response per command through a valid/ready response channel.
- Absorbs the RAM's 1-cycle read latency. Holds read data across response back-pressure, because the RAM re-samples its address on every non-write cycle.

Parameters:
DP, 512, RAM depth in words
DW, 32, data width
MW, 4, byte-mask width (DW/8)
AW, 32, bus address width
RAW, 9, RAM word-index width (log2 DP)
BASE_ADDR, 32'h8000_0000, TCM base byte address, aligned to DP*4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted this cycle when valid&ready
cmd_read  in  1  1 = read, 0 = write
cmd_addr  in  AW  byte address; bits [1:0] ignored
cmd_wdata  in  DW  write data
cmd_wmask  in  MW  byte write mask
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when valid&ready
rsp_rdata  out  DW  read data; 0 for writes and errors
rsp_err  out  1  address outside TCM window
ram_addr  out  AW  word index to sim_ram; upper AW-RAW bits 0
ram_din  out  DW  write data to sim_ram
ram_we  out  1  write enable to sim_ram
ram_wem  out  MW  byte mask to sim_ram
ram_dout  in  DW  sim_ram read data, valid the cycle after the read is sampled

Behaviour:
- Reset:
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=0.
  - ram_we=0; all internal state cleared.
  - A registered enable flop (reset 0, set 1 on the first clk edge after release) gates cmd_ready. No command is accepted in the first cycle after reset release.
- Accept condition:
  - acc = cmd_valid & cmd_ready.
  - cmd_ready = en_q & (~rsp_valid | rsp_ready). One response stage; full throughput when rsp_ready stays high.
- Address handling:
  - in_range = (cmd_addr[AW-1:RAW+2] == BASE_ADDR[AW-1:RAW+2]).
  - ram_addr = {0, cmd_addr[RAW+1:2]}, driven combinationally every cycle.
- RAM write:
  - ram_we = acc & ~cmd_read & in_range.
  - ram_din = cmd_wdata; ram_wem = cmd_wmask.
  - wmask=0 still asserts ram_we (no bytes change) and still returns a response.
- Out-of-range commands: no RAM write. Response has rsp_err=1 and rsp_rdata=0.
- Response timing: a command accepted at edge N produces rsp_valid=1 in the cycle after edge N (latency 1), for both reads and writes.
- Registered response state: is_read_q, err_q, fresh_q and hold_q[DW].
  - On acc: is_read_q = cmd_read & in_range; err_q = ~in_range; fresh_q = 1.
  - If rsp_valid & ~rsp_ready & fresh_q at an edge: hold_q <= ram_dout and fresh_q <= 0, so the data is captured before the RAM's addr_r moves.
- Read data mux: rsp_rdata = ~is_read_q ? 0 : (fresh_q ? ram_dout : hold_q).
- rsp_valid clear: on rsp_valid & rsp_ready with no new acc, rsp_valid <= 0.
  - Handshake and new accept in the same cycle: rsp_valid stays 1 and the state loads the new command (back-to-back).
- Stability under back-pressure: rsp_valid, rsp_err and rsp_rdata are stable until handshake.
- Reset mid-transaction: the pending response is discarded. No RAM write is issued while rst_n is low or in the first cycle after release.

Test Plan:
- Reset release, cmd_valid=1 read of 0x8000_0000 at cycle 0 -> cmd_ready=0 at cycle 0. Accepted at cycle 1; rsp_valid=1 at cycle 2 with RAM word 0 data, rsp_err=0.
- Write 0xDEADBEEF mask 4'b0011 to 0x8000_0010, then read the same address -> ram_we=1 for one cycle with ram_addr=4. Read returns old bytes [31:16] and 0xBEEF in [15:0].
- Read 0x8000_0008 with rsp_ready=0 for 5 cycles while cmd_addr toggles -> cmd_ready=0 throughout. rsp_rdata stays equal to word 2 (via hold_q); single response on release.
- Four back-to-back reads of words 0..3 with rsp_ready=1 -> four consecutive rsp_valid cycles with in-order data and no bubbles.
- Write to 0x9000_0000 -> ram_we stays 0; rsp_err=1, rsp_rdata=0. The following in-range read has rsp_err=0.
- Assert rst_n=0 while a response is stalled -> rsp_valid drops asynchronously to 0. After release there is no stale response and no RAM write.
